pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order pipelined processor. It merges load-use stall detection and EX-stage operand forwarding into one block driven by a shifting destination-tag pipeline. Pipeline depth after EX and load-result latency are configurable, and the block adds flush handling and saturating performance counters. It sits beside the ID/EX pipeline register, consuming decoded ID-stage fields and driving the PC/IF-ID write enables and the EX operand muxes.

## Interface
- `AW`, default 5: register-index width.
- `DEPTH`, default 2: post-EX stages carrying a writeback result (EX/MEM … MEM/WB). Legal range 1..7.
- `LOAD_STAGE`, default 2: first post-EX stage at which load data is forwardable. Legal range 1..DEPTH.
- `CW`, default 32: counter width.
- `SW`: derived, `$clog2(DEPTH+1)`, the forward-select width.
- `clk`, in, 1: clock; all state updates on rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_src_a`, `id_src_b`, in, AW: ID source register indices (rs, rt).
- `id_use_a`, `id_use_b`, in, 1: the corresponding source is actually read.
- `id_wen`, in, 1: the ID instruction writes a register.
- `id_dst`, in, AW: ID destination index, after the RegDst mux.
- `id_is_load`, in, 1: the ID instruction is a load.
- `flush`, in, 1: branch/jump redirect; kills the ID instruction.
- `stall`, out, 1: hold PC and IF/ID; insert a bubble into EX.
- `ex_fwd_sel_a`, `ex_fwd_sel_b`, out, SW: EX operand source. 0 selects the register file; k selects post-EX stage k's result.
- `stall_count`, out, CW: cycles with `stall`=1.
- `fwd_count`, out, CW: EX instructions with at least one nonzero forward select.

## Operation
- Tag pipeline entries 0..DEPTH. Entry 0 is the EX instruction; entry k is post-EX stage k.
- Each entry holds `valid`, `wen`, `dst`, `is_load`.
- Every cycle, entry k ← entry k−1 for k ≥ 1.
- Entry 0 ← ID fields when `id_valid & ~stall & ~flush`; otherwise entry 0 ← bubble (`valid`=0).
- Ready stage: 1 for non-loads, LOAD_STAGE for loads.
- Match of an entry to a source s: `valid & wen & dst==s & s!=0 & use`.
- Search runs over entries 0..DEPTH−1; the youngest (lowest index) match wins. Entry DEPTH retires to the register file. The register file is write-before-read, so retired values come from the regfile (select 0).
- Hazard: the winning match at entry j has j+1 < ready stage.
- `stall` = `id_valid & ~flush & (hazard_a | hazard_b)`. This is combinational from the inputs and the tag state.
- On every cycle without a stall, `ex_fwd_sel_x` ← j+1 if a match wins, else 0. On a stall or flush, both selects ← 0.
- Counters saturate at all-ones. `fwd_count` increments when the entry-0 load is valid and either computed select is nonzero.
- `flush` together with a hazard: flush wins, `stall`=0, bubble enters EX.

## Timing
- Reset values: all entries invalid, both selects 0, both counters 0, `stall`=0.
- Asserting `rst_n` mid-operation clears all in-flight tags immediately.
- Forward selects are registered and valid during the cycle the instruction occupies EX.
- Stall length is `ready_stage − (j+1)` cycles. With defaults, a load-use stall is exactly 1 cycle.
- `stall` never asserts for two consecutive cycles when `LOAD_STAGE` ≤ 2.

## Structure
- Package `pipe_pkg` holds:
  - the `hz_tag_t` struct (`valid`, `wen`, `dst`, `is_load`);
  - the `REG_ZERO` constant;
  - the `FWD_RF`=0 select constant.
- Sub-module `youngest_match`: a parametrised priority encoder over DEPTH entries. It returns the hit flag, the index and `is_load`, and is instantiated once per source operand.

## Test plan
- Load dst=8 at ID, then a consumer with src_a=8 at ID on the next cycle:
  - `stall`=1 for exactly 1 cycle;
  - the consumer then reaches EX with `ex_fwd_sel_a`=2;
  - `stall_count`=1.
- ALU op dst=9, then the next instruction with src_b=9 → no stall; EX `ex_fwd_sel_b`=1.
- ALU op dst=9, one unrelated instruction, then a consumer of 9 → `ex_fwd_sel_a`=2.
- Two back-to-back writers of dst=10, then a consumer of 10 → `ex_fwd_sel_a`=1 (youngest wins).
- Writer with dst=0 followed by a consumer of 0 → selects 0, no stall.
- Load-use hazard with `flush`=1 in the same cycle:
  - `stall`=0 and the EX entry is a bubble;
  - `rst_n` pulsed low mid-stream → all selects and counters return to 0 asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: tag type and constants shared by the hazard/forwarding controller.
`default_nettype none

package pipe_pkg;

  // Tags carry destinations at a fixed width so the type is parameter-free;
  // narrower register indices are zero-extended into this field.
  localparam int TAG_AW = 8;

  localparam logic [TAG_AW-1:0] REG_ZERO = '0;
  localparam int                FWD_RF   = 0;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [TAG_AW-1:0] dst;
    logic              is_load;
  } hz_tag_t;

endpackage

`default_nettype wire

// File: rtl/youngest_match.sv
// youngest_match: priority encoder returning the lowest-index tag writing src.
`default_nettype none

module youngest_match
  import pipe_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 2,
  parameter int SW    = 2
) (
  input  hz_tag_t         tags [DEPTH],
  input  logic [AW-1:0]   src,
  input  logic            src_used,
  output logic            hit,
  output logic [SW-1:0]   idx,
  output logic            is_load
);

  logic [TAG_AW-1:0] src_ext;

  assign src_ext = TAG_AW'(src);

  // Scan oldest to youngest so the youngest hit overwrites the result last.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (tags[k].valid && tags[k].wen && (tags[k].dst == src_ext) &&
          (src_ext != REG_ZERO) && src_used) begin
        hit     = 1'b1;
        idx     = SW'(k);
        is_load = tags[k].is_load;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall detection and EX operand forwarding driven
// by a shifting destination-tag pipeline, with flush and saturating counters.
`default_nettype none

module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int AW         = 5,
  parameter int DEPTH      = 2,
  parameter int LOAD_STAGE = 2,
  parameter int CW         = 32,
  parameter int SW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_src_a,
  input  logic [AW-1:0] id_src_b,
  input  logic          id_use_a,
  input  logic          id_use_b,
  input  logic          id_wen,
  input  logic [AW-1:0] id_dst,
  input  logic          id_is_load,
  input  logic          flush,
  output logic          stall,
  output logic [SW-1:0] ex_fwd_sel_a,
  output logic [SW-1:0] ex_fwd_sel_b,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] fwd_count
);

  localparam logic [SW-1:0] READY_LD = SW'(LOAD_STAGE);

  // Entry DEPTH retires into a write-before-read register file, so only
  // entries 0..DEPTH-1 can ever win a match and need to be stored.
  hz_tag_t       tags [DEPTH];
  hz_tag_t       new_tag;

  logic          hit_a, hit_b;
  logic          ld_a, ld_b;
  logic [SW-1:0] idx_a, idx_b;
  logic [SW-1:0] cand_a, cand_b;
  logic          hazard_a, hazard_b;
  logic          issue;

  youngest_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_a (
    .tags     (tags),
    .src      (id_src_a),
    .src_used (id_use_a),
    .hit      (hit_a),
    .idx      (idx_a),
    .is_load  (ld_a)
  );

  youngest_match #(.AW(AW), .DEPTH(DEPTH), .SW(SW)) u_match_b (
    .tags     (tags),
    .src      (id_src_b),
    .src_used (id_use_b),
    .hit      (hit_b),
    .idx      (idx_b),
    .is_load  (ld_b)
  );

  assign cand_a = hit_a ? idx_a + SW'(1) : SW'(FWD_RF);
  assign cand_b = hit_b ? idx_b + SW'(1) : SW'(FWD_RF);

  // Non-loads are ready at stage 1, which every candidate already reaches.
  assign hazard_a = hit_a & ld_a & (cand_a < READY_LD);
  assign hazard_b = hit_b & ld_b & (cand_b < READY_LD);

  assign stall = id_valid & ~flush & (hazard_a | hazard_b);
  assign issue = id_valid & ~stall & ~flush;

  assign new_tag = '{valid:   issue,
                     wen:     id_wen,
                     dst:     TAG_AW'(id_dst),
                     is_load: id_is_load};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        tags[k] <= '0;
      end
      ex_fwd_sel_a <= SW'(FWD_RF);
      ex_fwd_sel_b <= SW'(FWD_RF);
      stall_count  <= '0;
      fwd_count    <= '0;
    end else begin
      tags[0] <= issue ? new_tag : '0;
      for (int k = 1; k < DEPTH; k++) begin
        tags[k] <= tags[k-1];
      end

      if (stall || flush) begin
        ex_fwd_sel_a <= SW'(FWD_RF);
        ex_fwd_sel_b <= SW'(FWD_RF);
      end else begin
        ex_fwd_sel_a <= cand_a;
        ex_fwd_sel_b <= cand_b;
      end

      if (stall && (stall_count != '1)) begin
        stall_count <= stall_count + CW'(1);
      end
      if (issue && ((cand_a != '0) || (cand_b != '0)) && (fwd_count != '1)) begin
        fwd_count <= fwd_count + CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with literal expectations plus a
// history-based reference model compared against the DUT every cycle.
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int AW         = 5;
  localparam int DEPTH      = 2;
  localparam int LOAD_STAGE = 2;
  localparam int CW         = 32;
  localparam int SW         = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src_a = '0;
  logic [AW-1:0] id_src_b = '0;
  logic          id_use_a = 1'b0;
  logic          id_use_b = 1'b0;
  logic          id_wen = 1'b0;
  logic [AW-1:0] id_dst = '0;
  logic          id_is_load = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [SW-1:0] ex_fwd_sel_a;
  logic [SW-1:0] ex_fwd_sel_b;
  logic [CW-1:0] stall_count;
  logic [CW-1:0] fwd_count;

  int vectors = 0;
  int miscompares = 0;

  pipe_hazard_ctrl #(
    .AW(AW), .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .CW(CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_src_a     (id_src_a),
    .id_src_b     (id_src_b),
    .id_use_a     (id_use_a),
    .id_use_b     (id_use_b),
    .id_wen       (id_wen),
    .id_dst       (id_dst),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .stall        (stall),
    .ex_fwd_sel_a (ex_fwd_sel_a),
    .ex_fwd_sel_b (ex_fwd_sel_b),
    .stall_count  (stall_count),
    .fwd_count    (fwd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: hist[k] is the instruction that entered EX k cycles ago.
  typedef struct {
    bit v;
    bit w;
    bit ld;
    int d;
  } rec_t;

  rec_t        hist [DEPTH];
  int          m_sel_a, m_sel_b;
  longint      m_stall_cnt, m_fwd_cnt;
  localparam longint CMAX = (64'd1 << CW) - 1;

  function automatic void look(input int s, input bit u, output int sel, output bit hz);
    sel = 0;
    hz  = 1'b0;
    if (u && s != 0) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (hist[k].v && hist[k].w && hist[k].d == s) begin
          sel = k + 1;
          hz  = ((hist[k].ld ? LOAD_STAGE : 1) > k + 1);
          break;
        end
      end
    end
  endfunction

  function automatic void evaluate(output bit st, output int sa, output int sb);
    bit ha, hb;
    look(int'(id_src_a), id_use_a, sa, ha);
    look(int'(id_src_b), id_use_b, sb, hb);
    st = id_valid && !flush && (ha || hb);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit st;
    int sa, sb;
    bit go;
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hist[k] = '{v: 1'b0, w: 1'b0, ld: 1'b0, d: 0};
      m_sel_a = 0;
      m_sel_b = 0;
      m_stall_cnt = 0;
      m_fwd_cnt = 0;
    end else begin
      evaluate(st, sa, sb);
      go = id_valid && !st && !flush;
      m_sel_a = (st || flush) ? 0 : sa;
      m_sel_b = (st || flush) ? 0 : sb;
      if (st && m_stall_cnt < CMAX) m_stall_cnt++;
      if (go && (sa != 0 || sb != 0) && m_fwd_cnt < CMAX) m_fwd_cnt++;
      for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = '{v: go, w: id_wen, ld: id_is_load, d: int'(id_dst)};
    end
  end

  // Compare process: mid-cycle, against the model.
  always @(negedge clk) begin
    bit st;
    int sa, sb;
    evaluate(st, sa, sb);
    chk("stall", 64'(stall), 64'(st));
    chk("ex_fwd_sel_a", 64'(ex_fwd_sel_a), 64'(m_sel_a));
    chk("ex_fwd_sel_b", 64'(ex_fwd_sel_b), 64'(m_sel_b));
    chk("stall_count", 64'(stall_count), 64'(m_stall_cnt));
    chk("fwd_count", 64'(fwd_count), 64'(m_fwd_cnt));
  end

  // Presents one ID instruction and holds it until it is no longer stalled.
  // Returns with the instruction in EX, one time unit after the edge.
  task automatic issue(input bit v, input int dst, input bit wen, input bit ld,
                       input int sa, input bit ua, input int sb, input bit ub,
                       input bit fl, output int nstall);
    bit st;
    bit done;
    nstall = 0;
    done = 1'b0;
    id_valid = v; id_dst = AW'(dst); id_wen = wen; id_is_load = ld;
    id_src_a = AW'(sa); id_use_a = ua; id_src_b = AW'(sb); id_use_b = ub;
    flush = fl;
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      st = stall;
      @(posedge clk);
      #1;
      if (st) nstall++;
      else done = 1'b1;
    end
    if (!done) chk("issue_timeout", 64'(1), 64'(0));
    id_valid = 1'b0; id_use_a = 1'b0; id_use_b = 1'b0; id_wen = 1'b0;
    id_is_load = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    int ns;
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, ns);
  endtask

  initial begin
    int ns;
    longint fc;
    @(posedge clk);
    #1;
    chk("reset_stall", 64'(stall), 64'(0));
    chk("reset_sel_a", 64'(ex_fwd_sel_a), 64'(0));
    chk("reset_stall_count", 64'(stall_count), 64'(0));
    rst_n = 1'b1;
    idle(2);

    // Load-use: one stall, then forwarded from post-EX stage 2.
    issue(1, 8, 1, 1, 0, 0, 0, 0, 0, ns);
    issue(1, 11, 1, 0, 8, 1, 0, 0, 0, ns);
    chk("loaduse_stalls", 64'(ns), 64'(1));
    chk("loaduse_sel_a", 64'(ex_fwd_sel_a), 64'(2));
    chk("loaduse_stall_count", 64'(stall_count), 64'(1));
    chk("loaduse_fwd_count", 64'(fwd_count), 64'(1));
    idle(3);

    // ALU back-to-back.
    issue(1, 9, 1, 0, 0, 0, 0, 0, 0, ns);
    issue(1, 12, 1, 0, 0, 0, 9, 1, 0, ns);
    chk("alu_stalls", 64'(ns), 64'(0));
    chk("alu_sel_b", 64'(ex_fwd_sel_b), 64'(1));
    idle(3);

    // ALU with one unrelated instruction in between.
    issue(1, 9, 1, 0, 0, 0, 0, 0, 0, ns);
    issue(1, 3, 1, 0, 1, 1, 2, 1, 0, ns);
    issue(1, 13, 1, 0, 9, 1, 0, 0, 0, ns);
    chk("alu_gap_sel_a", 64'(ex_fwd_sel_a), 64'(2));
    idle(3);

    // Two writers of 10: youngest wins.
    issue(1, 10, 1, 0, 0, 0, 0, 0, 0, ns);
    issue(1, 10, 1, 0, 0, 0, 0, 0, 0, ns);
    issue(1, 14, 1, 0, 10, 1, 0, 0, 0, ns);
    chk("youngest_sel_a", 64'(ex_fwd_sel_a), 64'(1));
    idle(3);

    // Register zero never forwards.
    issue(1, 0, 1, 1, 0, 0, 0, 0, 0, ns);
    issue(1, 15, 1, 0, 0, 1, 0, 1, 0, ns);
    chk("r0_stalls", 64'(ns), 64'(0));
    chk("r0_sel_a", 64'(ex_fwd_sel_a), 64'(0));
    chk("r0_sel_b", 64'(ex_fwd_sel_b), 64'(0));
    idle(3);

    // Load-use hazard with flush: no stall, bubble enters EX.
    fc = longint'(fwd_count);
    issue(1, 8, 1, 1, 0, 0, 0, 0, 0, ns);
    issue(1, 8, 1, 0, 8, 1, 0, 0, 1, ns);
    chk("flush_stalls", 64'(ns), 64'(0));
    chk("flush_sel_a", 64'(ex_fwd_sel_a), 64'(0));
    chk("flush_fwd_count", 64'(fwd_count), 64'(fc));
    issue(1, 16, 1, 0, 8, 1, 0, 0, 0, ns);
    chk("after_flush_sel_a", 64'(ex_fwd_sel_a), 64'(2));
    idle(3);

    // Both operands forwarded from different stages.
    issue(1, 5, 1, 1, 0, 0, 0, 0, 0, ns);
    issue(1, 6, 1, 0, 0, 0, 0, 0, 0, ns);
    issue(1, 17, 1, 0, 5, 1, 6, 1, 0, ns);
    chk("dual_sel_a", 64'(ex_fwd_sel_a), 64'(2));
    chk("dual_sel_b", 64'(ex_fwd_sel_b), 64'(1));
    idle(3);

    // Short pseudo-random run over a small register set.
    for (int i = 0; i < 150; i++) begin
      issue(($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom),
            ($urandom_range(0, 7) == 0), ns);
      if (ns > 1) chk("stall_run_len", 64'(ns), 64'(1));
    end
    idle(2);

    // Asynchronous reset mid-stream with a load in flight.
    issue(1, 8, 1, 1, 0, 0, 0, 0, 0, ns);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel_a", 64'(ex_fwd_sel_a), 64'(0));
    chk("arst_sel_b", 64'(ex_fwd_sel_b), 64'(0));
    chk("arst_stall_count", 64'(stall_count), 64'(0));
    chk("arst_fwd_count", 64'(fwd_count), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(1, 18, 1, 0, 8, 1, 0, 0, 0, ns);
    chk("post_rst_stalls", 64'(ns), 64'(0));
    chk("post_rst_sel_a", 64'(ex_fwd_sel_a), 64'(0));
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
